// File: rtl/ucdp_latch_wrctrl.sv
// Write-side controller for latch-based row arrays. It takes valid/ready write requests and drives a
// registered one-hot row load strobe and shared row data with a full cycle of hold margin.
module ucdp_latch_wrctrl #(
  parameter int unsigned width_p     = 8,
  parameter int unsigned depth_p     = 4,
  parameter int unsigned addrwidth_p = $clog2(depth_p)
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_an_i,
  input  logic                   dft_mode_scan_mode_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [addrwidth_p-1:0] wr_addr_i,
  input  logic [width_p-1:0]     wr_data_i,
  output logic [depth_p-1:0]     ld_o,
  output logic [width_p-1:0]     d_o,
  output logic                   busy_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [addrwidth_p:0] DEPTH_L = (addrwidth_p+1)'(depth_p);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_err;
  logic [depth_p-1:0]   r_ld;
  logic [width_p-1:0]   r_d;
  logic                 w_accept;
  logic                 w_in_range;
  logic [depth_p-1:0]   w_ld_dec;

  assign w_accept   = wr_valid_i & r_ready;
  assign w_in_range = ({1'b0, wr_addr_i} < DEPTH_L);

  always_comb begin
    w_ld_dec = '0;
    for (int unsigned i = 0; i < depth_p; i++) begin
      w_ld_dec[i] = (wr_addr_i == addrwidth_p'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && w_in_range) w_state_nxt = LOAD;
      end
      LOAD: w_state_nxt = HOLD;
      HOLD: begin
        if (w_accept && w_in_range) w_state_nxt = LOAD;
        else                        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) r_state <= IDLE;
    else                r_state <= w_state_nxt;
  end

  // The one-hot strobe register holds the accepted row address; it is loaded
  // at the accept edge so the strobe rises one cycle later straight from a flop.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_ld    <= '0;
      r_d     <= '0;
    end else begin
      r_ready <= (w_state_nxt != LOAD);
      r_busy  <= (w_state_nxt != IDLE);
      r_err   <= w_accept & ~w_in_range;
      r_ld    <= (w_state_nxt == LOAD) ? w_ld_dec : '0;
      if (w_accept) r_d <= wr_data_i;
    end
  end

  assign wr_ready_o = r_ready;
  assign busy_o     = r_busy;
  assign err_o      = r_err;
  assign d_o        = r_d;
  assign ld_o       = r_ld & {depth_p{~dft_mode_scan_mode_i}};

endmodule

// File: tb/tb_ucdp_latch_wrctrl.sv
// Directed bench for ucdp_latch_wrctrl: a depth-4 instance for the main flows and a depth-5 instance
// for out-of-range addresses.
module tb_ucdp_latch_wrctrl;

  logic       clk;
  logic       rst_n;
  logic       scan;

  logic       v4;
  logic [1:0] a4;
  logic [7:0] dat4;
  logic       rdy4;
  logic [3:0] ld4;
  logic [7:0] d4;
  logic       busy4;
  logic       err4;

  logic       v5;
  logic [2:0] a5;
  logic [7:0] dat5;
  logic       rdy5;
  logic [4:0] ld5;
  logic [7:0] d5;
  logic       busy5;
  logic       err5;

  int n_checks = 0;
  int n_fail   = 0;

  ucdp_latch_wrctrl #(.width_p(8), .depth_p(4)) u_dut4 (
    .main_clk_i          (clk),
    .main_rst_an_i       (rst_n),
    .dft_mode_scan_mode_i(scan),
    .wr_valid_i          (v4),
    .wr_ready_o          (rdy4),
    .wr_addr_i           (a4),
    .wr_data_i           (dat4),
    .ld_o                (ld4),
    .d_o                 (d4),
    .busy_o              (busy4),
    .err_o               (err4)
  );

  ucdp_latch_wrctrl #(.width_p(8), .depth_p(5)) u_dut5 (
    .main_clk_i          (clk),
    .main_rst_an_i       (rst_n),
    .dft_mode_scan_mode_i(scan),
    .wr_valid_i          (v5),
    .wr_ready_o          (rdy5),
    .wr_addr_i           (a5),
    .wr_data_i           (dat5),
    .ld_o                (ld5),
    .d_o                 (d5),
    .busy_o              (busy5),
    .err_o               (err5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] ld, input logic [7:0] d,
                      input logic busy, input logic rdy);
    check({tag, ".ld"},   32'(ld4),   32'(ld));
    check({tag, ".d"},    32'(d4),    32'(d));
    check({tag, ".busy"}, 32'(busy4), 32'(busy));
    check({tag, ".rdy"},  32'(rdy4),  32'(rdy));
  endtask

  task automatic chk5(input string tag, input logic [4:0] ld, input logic [7:0] d,
                      input logic busy, input logic rdy, input logic err);
    check({tag, ".ld"},   32'(ld5),   32'(ld));
    check({tag, ".d"},    32'(d5),    32'(d));
    check({tag, ".busy"}, 32'(busy5), 32'(busy));
    check({tag, ".rdy"},  32'(rdy5),  32'(rdy));
    check({tag, ".err"},  32'(err5),  32'(err));
  endtask

  initial begin
    rst_n = 1'b0; scan = 1'b0;
    v4 = 1'b0; a4 = '0; dat4 = '0;
    v5 = 1'b0; a5 = '0; dat5 = '0;
    #12;
    chk4("rst4", 4'b0000, 8'h00, 1'b0, 1'b1);
    check("rst4.err", 32'(err4), 32'd0);
    chk5("rst5", 5'b00000, 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    chk4("idle", 4'b0000, 8'h00, 1'b0, 1'b1);

    // single write addr 2, data A5
    v4 = 1'b1; a4 = 2'd2; dat4 = 8'hA5;
    step();
    v4 = 1'b0;
    chk4("w1.c1", 4'b0100, 8'hA5, 1'b1, 1'b0);
    step();
    chk4("w1.c2", 4'b0000, 8'hA5, 1'b1, 1'b1);
    step();
    chk4("w1.c3", 4'b0000, 8'hA5, 1'b0, 1'b1);

    // back-to-back with valid held high
    v4 = 1'b1; a4 = 2'd0; dat4 = 8'h11;
    step();
    chk4("b2b.l0", 4'b0001, 8'h11, 1'b1, 1'b0);
    a4 = 2'd3; dat4 = 8'h22;
    step();
    chk4("b2b.h0", 4'b0000, 8'h11, 1'b1, 1'b1);
    step();
    chk4("b2b.l1", 4'b1000, 8'h22, 1'b1, 1'b0);
    a4 = 2'd1; dat4 = 8'h33;
    step();
    chk4("b2b.h1", 4'b0000, 8'h22, 1'b1, 1'b1);
    step();
    v4 = 1'b0;
    chk4("b2b.l2", 4'b0010, 8'h33, 1'b1, 1'b0);
    step();
    chk4("b2b.h2", 4'b0000, 8'h33, 1'b1, 1'b1);
    step();
    chk4("b2b.idle", 4'b0000, 8'h33, 1'b0, 1'b1);

    // out-of-range on depth 5, two back-to-back errors
    v5 = 1'b1; a5 = 3'd7; dat5 = 8'h5A;
    step();
    chk5("err.a", 5'b00000, 8'h5A, 1'b0, 1'b1, 1'b1);
    a5 = 3'd5; dat5 = 8'h3C;
    step();
    v5 = 1'b0;
    chk5("err.b", 5'b00000, 8'h3C, 1'b0, 1'b1, 1'b1);
    step();
    chk5("err.c", 5'b00000, 8'h3C, 1'b0, 1'b1, 1'b0);

    // in-range to row 4, then out-of-range accepted from HOLD
    v5 = 1'b1; a5 = 3'd4; dat5 = 8'h01;
    step();
    chk5("hoor.l", 5'b10000, 8'h01, 1'b1, 1'b0, 1'b0);
    a5 = 3'd6; dat5 = 8'h02;
    step();
    chk5("hoor.h", 5'b00000, 8'h01, 1'b1, 1'b1, 1'b0);
    step();
    v5 = 1'b0;
    chk5("hoor.e", 5'b00000, 8'h02, 1'b0, 1'b1, 1'b1);
    step();
    chk5("hoor.i", 5'b00000, 8'h02, 1'b0, 1'b1, 1'b0);

    // asynchronous reset during LOAD
    v4 = 1'b1; a4 = 2'd3; dat4 = 8'h77;
    step();
    v4 = 1'b0;
    chk4("arst.l", 4'b1000, 8'h77, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk4("arst.now", 4'b0000, 8'h00, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    step();
    chk4("arst.idle", 4'b0000, 8'h00, 1'b0, 1'b1);
    step();
    chk4("arst.idle2", 4'b0000, 8'h00, 1'b0, 1'b1);

    // scan mode masks the strobe only
    scan = 1'b1;
    v4 = 1'b1; a4 = 2'd1; dat4 = 8'hC3;
    step();
    v4 = 1'b0;
    chk4("scan.l", 4'b0000, 8'hC3, 1'b1, 1'b0);
    scan = 1'b0;
    #1;
    check("scan.unmask", 32'(ld4), 32'h2);
    scan = 1'b1;
    #1;
    check("scan.remask", 32'(ld4), 32'h0);
    step();
    chk4("scan.h", 4'b0000, 8'hC3, 1'b1, 1'b1);
    step();
    chk4("scan.i", 4'b0000, 8'hC3, 1'b0, 1'b1);
    scan = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
